branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  async active-high reset.
REQ-002 SHALL have ports: ds_to_es_valid  in  1  decode offers a two-slot group; es_allowin  out  1  stage can accept.
REQ-003 SHALL have per slot k=1,2 inputs: ds_valid_k 1 (slot occupied); ds_pc_k 32; ds_br_op_k 4 (0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 7 b, 8 bl, 9 jirl, others treated as none); ds_src1_k 32; ds_src2_k 32; ds_offs_k 32 (sign-extended byte offset); ds_pred_taken_k 1; ds_pred_target_k 32.
REQ-004 SHALL have ports: ms_allowin  in  1  downstream accepts; ws_flush  in  1  exception/ertn flush; es_to_ms_valid  out  1  stage group fires.
REQ-005 SHALL have ports: bpu_es_bus1, bpu_es_bus2  out  70 each, packed MSB-first {flush, es_pc[31:0], jump_valid, need_jump, pre_fail, right_target[31:0], jump_type[1:0]}.
REQ-006 SHALL have ports: num_branch  out  32; num_mispredict  out  32 (statistics).

Function
REQ-007 Stage holds one two-slot group in registers es_valid, slot fields; es_allowin = !es_valid || ms_allowin, forced 0 in state KILL.
REQ-008 Group latched when ds_to_es_valid && es_allowin; es_valid cleared when es fires with no new group latched.
REQ-009 es_fire = es_valid && ms_allowin && !ws_flush; es_to_ms_valid = es_fire.
REQ-010 Bus fields SHALL be nonzero only in the es_fire cycle, so each branch is reported exactly once; all 70 bits zero otherwise.
REQ-011 is_br_k = ds_br_op_k in 1..9 and slot valid; jump_valid_k = es_fire && is_br_k && !squash_k.
REQ-012 Taken: beq src1==src2; bne !=; blt/bge signed compare; bltu/bgeu unsigned; b, bl, jirl always taken; need_jump_k = taken.
REQ-013 Target: jirl = src1+offs; others = pc+offs; 32-bit wrap-around, no overflow detect; right_target = taken ? target : pc+4.
REQ-014 jump_type: 2'b00 conditional, 2'b01 b, 2'b11 bl, 2'b10 jirl.
REQ-015 pre_fail_k = (pred_taken != taken) || (taken && pred_target != target); flush_k = jump_valid_k && pre_fail_k.
REQ-016 Non-branch slot with pred_taken=1 SHALL report jump_valid=0, flush=1, pre_fail=1, right_target=pc+4 (false-hit recovery) when it fires.
REQ-017 squash_2 = slot 1 flush condition true (branch or false-hit); a squashed slot 2 SHALL report all-zero bus.
REQ-018 es_pc = slot pc; at most one of flush1/flush2 asserts per cycle.
REQ-019 FSM: NORMAL -> KILL on es_fire with flush1||flush2; KILL -> NORMAL after exactly 1 cycle; in KILL, ds_to_es_valid ignored (wrong-path drop).
REQ-020 ws_flush SHALL clear es_valid next edge, force bus all-zero same cycle, and return FSM to NORMAL; ws_flush dominates a simultaneous ds latch.
REQ-021 num_branch += count of jump_valid slots (0,1,2) per cycle; num_mispredict += count of flush slots; both wrap modulo 2^32.

Reset
REQ-022 On reset asserted (asynchronously, any time incl. mid-stall): es_valid=0, FSM=NORMAL, counters=0, es_allowin=1, es_to_ms_valid=0, both buses zero.
REQ-023 Slot data registers need not reset; outputs SHALL not depend on them while es_valid=0.

Verification
REQ-024 Slot1 beq pc=0x1000, src1=src2=5, offs=0x40, pred_taken=0 -> bus1 flush=1, need_jump=1, pre_fail=1, right_target=0x1040, jump_type=00; slot2 bus zero; next cycle es_allowin=0.
REQ-025 Slot1 bltu src1=0xFFFFFFFF, src2=1, pred_taken=0; slot2 jirl pc=0x2004, src1=0x3000, offs=8, pred_target=0x3008 -> bus1 jump_valid=1 need_jump=0 flush=0; bus2 need_jump=1 flush=0 right_target=0x3008 jump_type=10; num_branch +2.
REQ-026 Group with bl held while ms_allowin=0 for 3 cycles -> bus zero for 3 cycles, reported once on release, num_branch +1 only.
REQ-027 Non-branch slot1 pred_taken=1, pc=0x500 -> bus1 flush=1, jump_valid=0, right_target=0x504; slot2 squashed.
REQ-028 ws_flush asserted with valid mispredicting group and ds_to_es_valid=1 -> bus zero, es_valid=0 next edge, counters unchanged; reset pulsed mid-KILL -> FSM NORMAL, es_allowin=1.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Decode-to-execute group handshake, per-slot branch operands and BPU update buses.
// The master side drives decode data and downstream handshake; the slave is the resolve unit.
interface branch_resolve_unit_if;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic        ds_valid_1;
  logic [31:0] ds_pc_1;
  logic [3:0]  ds_br_op_1;
  logic [31:0] ds_src1_1;
  logic [31:0] ds_src2_1;
  logic [31:0] ds_offs_1;
  logic        ds_pred_taken_1;
  logic [31:0] ds_pred_target_1;
  logic        ds_valid_2;
  logic [31:0] ds_pc_2;
  logic [3:0]  ds_br_op_2;
  logic [31:0] ds_src1_2;
  logic [31:0] ds_src2_2;
  logic [31:0] ds_offs_2;
  logic        ds_pred_taken_2;
  logic [31:0] ds_pred_target_2;
  logic        ms_allowin;
  logic        ws_flush;
  logic        es_to_ms_valid;
  logic [69:0] bpu_es_bus1;
  logic [69:0] bpu_es_bus2;
  logic [31:0] num_branch;
  logic [31:0] num_mispredict;

  modport master (
    output ds_to_es_valid, ds_valid_1, ds_pc_1, ds_br_op_1, ds_src1_1, ds_src2_1, ds_offs_1,
           ds_pred_taken_1, ds_pred_target_1, ds_valid_2, ds_pc_2, ds_br_op_2, ds_src1_2,
           ds_src2_2, ds_offs_2, ds_pred_taken_2, ds_pred_target_2, ms_allowin, ws_flush,
    input  es_allowin, es_to_ms_valid, bpu_es_bus1, bpu_es_bus2, num_branch, num_mispredict
  );

  modport slave (
    input  ds_to_es_valid, ds_valid_1, ds_pc_1, ds_br_op_1, ds_src1_1, ds_src2_1, ds_offs_1,
           ds_pred_taken_1, ds_pred_target_1, ds_valid_2, ds_pc_2, ds_br_op_2, ds_src1_2,
           ds_src2_2, ds_offs_2, ds_pred_taken_2, ds_pred_target_2, ms_allowin, ws_flush,
    output es_allowin, es_to_ms_valid, bpu_es_bus1, bpu_es_bus2, num_branch, num_mispredict
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution for a two-slot group: computes direction/target, detects
// mispredicts and false BTB hits, reports once per branch to the BPU and drops wrong-path groups.
module branch_resolve_unit (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_unit_if.slave  brif
);

  typedef enum logic [0:0] {StNormal, StKill} state_e;

  typedef struct packed {
    logic        valid;
    logic [3:0]  br_op;
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] offs;
    logic        pred_taken;
    logic [31:0] pred_target;
  } slot_t;

  typedef struct packed {
    logic        is_br;
    logic        taken;
    logic        pre_fail;
    logic [31:0] target;
    logic [1:0]  jump_type;
  } resolve_t;

  function automatic resolve_t resolve(input slot_t s);
    resolve_t r;
    logic     taken;
    r.is_br     = s.valid && (s.br_op >= 4'd1) && (s.br_op <= 4'd9);
    r.target    = (s.br_op == 4'd9) ? s.src1 + s.offs : s.pc + s.offs;
    r.jump_type = 2'b00;
    taken       = 1'b0;
    case (s.br_op)
      4'd1: taken = (s.src1 == s.src2);
      4'd2: taken = (s.src1 != s.src2);
      4'd3: taken = ($signed(s.src1) < $signed(s.src2));
      4'd4: taken = ($signed(s.src1) >= $signed(s.src2));
      4'd5: taken = (s.src1 < s.src2);
      4'd6: taken = (s.src1 >= s.src2);
      4'd7: begin taken = 1'b1; r.jump_type = 2'b01; end
      4'd8: begin taken = 1'b1; r.jump_type = 2'b11; end
      4'd9: begin taken = 1'b1; r.jump_type = 2'b10; end
      default: ;
    endcase
    r.taken = r.is_br && taken;
    // A non-branch slot has taken=0, so pre_fail reduces to pred_taken (false hit).
    r.pre_fail = (s.pred_taken != r.taken) || (r.taken && (s.pred_target != r.target));
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        es_valid_q, es_valid_d;
  slot_t       slot_q [2];
  slot_t       slot_in [2];
  resolve_t    res [2];
  logic [1:0]  report, flush, jump_valid, squash;
  logic        es_fire, latch;
  logic [69:0] bus [2];
  logic [31:0] num_branch_q, num_mispredict_q;

  assign slot_in[0] = {brif.ds_valid_1, brif.ds_br_op_1, brif.ds_pc_1, brif.ds_src1_1,
                       brif.ds_src2_1, brif.ds_offs_1, brif.ds_pred_taken_1,
                       brif.ds_pred_target_1};
  assign slot_in[1] = {brif.ds_valid_2, brif.ds_br_op_2, brif.ds_pc_2, brif.ds_src1_2,
                       brif.ds_src2_2, brif.ds_offs_2, brif.ds_pred_taken_2,
                       brif.ds_pred_target_2};

  assign res[0] = resolve(slot_q[0]);
  assign res[1] = resolve(slot_q[1]);

  assign brif.es_allowin     = (state_q == StNormal) && (!es_valid_q || brif.ms_allowin);
  assign es_fire             = es_valid_q && brif.ms_allowin && !brif.ws_flush;
  assign latch               = brif.ds_to_es_valid && brif.es_allowin && !brif.ws_flush;
  assign brif.es_to_ms_valid = es_fire;

  // Slot 2 is younger: anything that redirects slot 1 makes slot 2 wrong-path.
  assign squash = {slot_q[0].valid && res[0].pre_fail, 1'b0};

  always_comb begin
    report     = '0;
    flush      = '0;
    jump_valid = '0;
    bus[0]     = '0;
    bus[1]     = '0;
    for (int k = 0; k < 2; k++) begin
      report[k]     = es_fire && slot_q[k].valid && !squash[k] &&
                      (res[k].is_br || slot_q[k].pred_taken);
      flush[k]      = report[k] && res[k].pre_fail;
      jump_valid[k] = report[k] && res[k].is_br;
      if (report[k]) begin
        bus[k] = {flush[k], slot_q[k].pc, res[k].is_br, res[k].taken, res[k].pre_fail,
                  res[k].taken ? res[k].target : slot_q[k].pc + 32'd4, res[k].jump_type};
      end
    end
  end

  assign brif.bpu_es_bus1    = bus[0];
  assign brif.bpu_es_bus2    = bus[1];
  assign brif.num_branch     = num_branch_q;
  assign brif.num_mispredict = num_mispredict_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StNormal: if (es_fire && (|flush)) state_d = StKill;
      StKill:   state_d = StNormal;
      default:  state_d = StNormal;
    endcase
    if (brif.ws_flush) state_d = StNormal;
  end

  always_comb begin
    es_valid_d = es_valid_q;
    if (brif.ws_flush)  es_valid_d = 1'b0;
    else if (latch)     es_valid_d = 1'b1;
    else if (es_fire)   es_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StNormal;
      es_valid_q       <= 1'b0;
      num_branch_q     <= '0;
      num_mispredict_q <= '0;
    end else begin
      state_q          <= state_d;
      es_valid_q       <= es_valid_d;
      num_branch_q     <= num_branch_q + {31'd0, jump_valid[0]} + {31'd0, jump_valid[1]};
      num_mispredict_q <= num_mispredict_q + {31'd0, flush[0]} + {31'd0, flush[1]};
    end
  end

  // Slot payload is qualified by es_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (latch) begin
      slot_q[0] <= slot_in[0];
      slot_q[1] <= slot_in[1];
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed checks of branch_resolve_unit against a behavioural model.
module tb_branch_resolve_unit;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] pc, s1, s2, offs;
    logic        pt;
    logic [31:0] ptgt;
  } slot_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolve_unit_if bif ();

  branch_resolve_unit dut (
    .clk   (clk),
    .reset (reset),
    .brif  (bif)
  );

  int n_vec = 0;
  int n_err = 0;

  slot_t       in_s [2];
  slot_t       m_s  [2];
  logic        m_valid, m_kill;
  logic [31:0] m_nb, m_nm;

  logic        obs_allowin, obs_to_ms;
  logic [69:0] obs_bus1, obs_bus2;
  logic [31:0] obs_nb, obs_nm;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_branch(input slot_t s);
    return s.valid && s.op >= 4'd1 && s.op <= 4'd9;
  endfunction

  function automatic logic [31:0] ref_target(input slot_t s);
    return (s.op == 4'd9) ? s.s1 + s.offs : s.pc + s.offs;
  endfunction

  function automatic logic ref_taken(input slot_t s);
    if (!s.valid) return 1'b0;
    case (s.op)
      4'd1: return s.s1 == s.s2;
      4'd2: return s.s1 != s.s2;
      4'd3: return $signed(s.s1) < $signed(s.s2);
      4'd4: return !($signed(s.s1) < $signed(s.s2));
      4'd5: return s.s1 < s.s2;
      4'd6: return !(s.s1 < s.s2);
      4'd7, 4'd8, 4'd9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic wants_flush(input slot_t s);
    if (!s.valid) return 1'b0;
    if (!is_branch(s)) return s.pt;
    return (s.pt != ref_taken(s)) || (ref_taken(s) && s.ptgt != ref_target(s));
  endfunction

  function automatic logic [69:0] ref_bus(input slot_t s, input logic rep);
    logic [1:0]  jt;
    logic [31:0] rt;
    if (!rep) return '0;
    jt = (s.op == 4'd7) ? 2'b01 : (s.op == 4'd8) ? 2'b11 : (s.op == 4'd9) ? 2'b10 : 2'b00;
    rt = ref_taken(s) ? ref_target(s) : s.pc + 32'd4;
    return {wants_flush(s), s.pc, is_branch(s), ref_taken(s), wants_flush(s), rt, jt};
  endfunction

  function automatic slot_t rand_slot();
    slot_t s;
    s.valid = ($urandom_range(7) != 0);
    s.op    = 4'($urandom_range(11));
    s.pc    = $urandom & 32'hFFFF_FFFC;
    s.s1    = $urandom;
    s.s2    = ($urandom_range(3) == 0) ? s.s1 : $urandom;
    s.offs  = {{20{$urandom_range(1) == 1}}, 12'($urandom)};
    s.pt    = $urandom_range(1) == 1;
    s.ptgt  = ($urandom_range(1) == 1) ? ref_target(s) : $urandom;
    return s;
  endfunction

  task automatic drive_slots();
    bif.ds_valid_1 = in_s[0].valid; bif.ds_br_op_1 = in_s[0].op; bif.ds_pc_1 = in_s[0].pc;
    bif.ds_src1_1 = in_s[0].s1; bif.ds_src2_1 = in_s[0].s2; bif.ds_offs_1 = in_s[0].offs;
    bif.ds_pred_taken_1 = in_s[0].pt; bif.ds_pred_target_1 = in_s[0].ptgt;
    bif.ds_valid_2 = in_s[1].valid; bif.ds_br_op_2 = in_s[1].op; bif.ds_pc_2 = in_s[1].pc;
    bif.ds_src1_2 = in_s[1].s1; bif.ds_src2_2 = in_s[1].s2; bif.ds_offs_2 = in_s[1].offs;
    bif.ds_pred_taken_2 = in_s[1].pt; bif.ds_pred_target_2 = in_s[1].ptgt;
  endtask

  task automatic set_slot(input int k, input logic v, input logic [3:0] op,
                          input logic [31:0] pc, s1, s2, offs, input logic pt,
                          input logic [31:0] ptgt);
    in_s[k].valid = v; in_s[k].op = op; in_s[k].pc = pc; in_s[k].s1 = s1;
    in_s[k].s2 = s2; in_s[k].offs = offs; in_s[k].pt = pt; in_s[k].ptgt = ptgt;
    drive_slots();
  endtask

  // Called shortly after a rising edge; reset released before the next falling edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_allowin", 70'(bif.es_allowin), 70'(1));
    check("rst_to_ms", 70'(bif.es_to_ms_valid), 70'(0));
    check("rst_bus1", bif.bpu_es_bus1, 70'(0));
    check("rst_bus2", bif.bpu_es_bus2, 70'(0));
    check("rst_nb", 70'(bif.num_branch), 70'(0));
    check("rst_nm", 70'(bif.num_mispredict), 70'(0));
    m_valid = 1'b0; m_kill = 1'b0; m_nb = '0; m_nm = '0;
    #2 reset = 1'b0;
  endtask

  task automatic cycle();
    logic allow, fire, r1, r2, f1, f2, lat;
    @(negedge clk);
    allow = !m_kill && (!m_valid || bif.ms_allowin);
    fire  = m_valid && bif.ms_allowin && !bif.ws_flush;
    r1    = fire && m_s[0].valid && (is_branch(m_s[0]) || m_s[0].pt);
    r2    = fire && !wants_flush(m_s[0]) && m_s[1].valid && (is_branch(m_s[1]) || m_s[1].pt);
    f1    = r1 && wants_flush(m_s[0]);
    f2    = r2 && wants_flush(m_s[1]);
    obs_allowin = bif.es_allowin; obs_to_ms = bif.es_to_ms_valid;
    obs_bus1 = bif.bpu_es_bus1; obs_bus2 = bif.bpu_es_bus2;
    obs_nb = bif.num_branch; obs_nm = bif.num_mispredict;
    check("allowin", 70'(obs_allowin), 70'(allow));
    check("to_ms", 70'(obs_to_ms), 70'(fire));
    check("bus1", obs_bus1, ref_bus(m_s[0], r1));
    check("bus2", obs_bus2, ref_bus(m_s[1], r2));
    check("num_branch", 70'(obs_nb), 70'(m_nb));
    check("num_mispred", 70'(obs_nm), 70'(m_nm));
    m_nb = m_nb + 32'(r1 && is_branch(m_s[0])) + 32'(r2 && is_branch(m_s[1]));
    m_nm = m_nm + 32'(f1) + 32'(f2);
    lat  = bif.ds_to_es_valid && allow && !bif.ws_flush;
    if (bif.ws_flush) begin
      m_kill = 1'b0; m_valid = 1'b0;
    end else begin
      m_kill  = !m_kill && fire && (f1 || f2);
      m_valid = lat ? 1'b1 : (fire ? 1'b0 : m_valid);
    end
    if (lat) m_s = in_s;
    @(posedge clk);
    #1;
  endtask

  task automatic load_beq_group();
    set_slot(0, 1'b1, 4'd1, 32'h1000, 32'd5, 32'd5, 32'h40, 1'b0, 32'h0);
    set_slot(1, 1'b1, 4'd0, 32'h1004, 32'd0, 32'd0, 32'd0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    m_valid = 1'b0; m_kill = 1'b0; m_nb = '0; m_nm = '0;
    in_s[0] = '{default: '0}; in_s[1] = '{default: '0}; m_s = in_s;
    drive_slots();
    bif.ds_to_es_valid = 1'b0; bif.ms_allowin = 1'b0; bif.ws_flush = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // beq mispredicted not-taken
    load_beq_group();
    bif.ds_to_es_valid = 1'b1; bif.ms_allowin = 1'b1;
    cycle();
    bif.ds_to_es_valid = 1'b0;
    cycle();
    check("beq_bus1", obs_bus1, {1'b1, 32'h1000, 1'b1, 1'b1, 1'b1, 32'h1040, 2'b00});
    check("beq_bus2", obs_bus2, 70'(0));
    cycle();
    check("beq_kill_allowin", 70'(obs_allowin), 70'(0));

    // bltu not taken + correctly predicted jirl
    do_reset();
    set_slot(0, 1'b1, 4'd5, 32'h2000, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
    set_slot(1, 1'b1, 4'd9, 32'h2004, 32'h3000, 32'd0, 32'd8, 1'b1, 32'h3008);
    bif.ds_to_es_valid = 1'b1; bif.ms_allowin = 1'b1;
    cycle();
    bif.ds_to_es_valid = 1'b0;
    cycle();
    check("bltu_bus1", obs_bus1, {1'b0, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h2004, 2'b00});
    check("jirl_bus2", obs_bus2, {1'b0, 32'h2004, 1'b1, 1'b1, 1'b0, 32'h3008, 2'b10});
    cycle();
    check("pair_nb", 70'(obs_nb), 70'(2));

    // bl held by downstream stall
    do_reset();
    set_slot(0, 1'b1, 4'd8, 32'h4000, 32'd0, 32'd0, 32'h100, 1'b1, 32'h4100);
    set_slot(1, 1'b0, 4'd0, 32'h4004, 32'd0, 32'd0, 32'd0, 1'b0, 32'h0);
    bif.ds_to_es_valid = 1'b1; bif.ms_allowin = 1'b1;
    cycle();
    bif.ds_to_es_valid = 1'b0; bif.ms_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_bus1", obs_bus1, 70'(0));
    end
    bif.ms_allowin = 1'b1;
    cycle();
    check("bl_bus1", obs_bus1, {1'b0, 32'h4000, 1'b1, 1'b1, 1'b0, 32'h4100, 2'b11});
    cycle();
    cycle();
    check("bl_nb_once", 70'(obs_nb), 70'(1));

    // false BTB hit on non-branch squashes slot 2
    do_reset();
    set_slot(0, 1'b1, 4'd0, 32'h500, 32'd0, 32'd0, 32'd0, 1'b1, 32'h900);
    set_slot(1, 1'b1, 4'd1, 32'h504, 32'd7, 32'd7, 32'd4, 1'b0, 32'h0);
    bif.ds_to_es_valid = 1'b1; bif.ms_allowin = 1'b1;
    cycle();
    bif.ds_to_es_valid = 1'b0;
    cycle();
    check("fhit_bus1", obs_bus1, {1'b1, 32'h500, 1'b0, 1'b0, 1'b1, 32'h504, 2'b00});
    check("fhit_bus2", obs_bus2, 70'(0));

    // ws_flush dominates firing and latching
    do_reset();
    load_beq_group();
    bif.ds_to_es_valid = 1'b1; bif.ms_allowin = 1'b1;
    cycle();
    bif.ws_flush = 1'b1;
    cycle();
    check("wsf_bus1", obs_bus1, 70'(0));
    bif.ws_flush = 1'b0; bif.ds_to_es_valid = 1'b0; bif.ms_allowin = 1'b0;
    cycle();
    check("wsf_allowin", 70'(obs_allowin), 70'(1));
    check("wsf_nm", 70'(obs_nm), 70'(0));
    // reset during KILL
    bif.ds_to_es_valid = 1'b1; bif.ms_allowin = 1'b1;
    cycle();
    bif.ds_to_es_valid = 1'b0;
    cycle();
    do_reset();
    cycle();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      in_s[0] = rand_slot();
      in_s[1] = rand_slot();
      drive_slots();
      bif.ds_to_es_valid = $urandom_range(9) < 7;
      bif.ms_allowin     = $urandom_range(3) != 0;
      bif.ws_flush       = $urandom_range(19) == 0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
